spi_slave: RTL and testbench

- SPI slave endpoint: the responder to the team's spi_master core. Used in loopback benches and in designs where the FPGA is the SPI peripheral.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, frame length set at runtime.
- All SPI pins are oversampled in the CLK domain; there is no logic clocked by SPI_CLK.
- User side mirrors spi_master: WDATA/WENA for transmit, RDATA/RENA for receive, plus BUSY and INT.

---
 rtl/spi_slave.sv | 180 ++++++++++++++++++
 tb/tb_spi_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Mode-0 SPI slave, MSB first, runtime frame length; all SPI pins
//            oversampled in the CLK domain.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int DWIDTH      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       SPI_CLK,
    input  logic                       SPI_SS,
    input  logic                       SPI_MOSI,
    output logic                       SPI_MISO,
    output logic                       SPI_MISO_OE,
    input  logic [DWIDTH-1:0]          WDATA,
    input  logic                       WENA,
    output logic [DWIDTH-1:0]          RDATA,
    output logic                       RVALID,
    input  logic                       RENA,
    input  logic [$clog2(DWIDTH)-1:0]  LENGTH,
    output logic                       TX_FULL,
    output logic                       BUSY,
    output logic                       OVERRUN,
    output logic                       UNDERRUN,
    input  logic                       ERR_CLR,
    output logic                       INT
);

    localparam int c_LW = $clog2(DWIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic [SYNC_STAGES:0]   r_settle;
    logic                   r_armed;
    logic                   r_sclk_q, r_ss_q;
    logic                   r_rise, r_fall, r_ss_fall, r_ss_rise, r_mosi;

    logic                   w_sclk_s, w_ss_s, w_mosi_s;

    state_t                 r_state;
    logic [c_LW-1:0]        r_len, r_bitcnt;
    logic [DWIDTH-1:0]      r_tx_sh, r_tx_buf, r_rdata;
    logic [DWIDTH-2:0]      r_rx_sh;
    logic                   r_tx_full, r_rvalid, r_int;
    logic                   r_overrun, r_underrun, r_busy, r_oe;

    logic [DWIDTH-1:0]      w_mask, w_rx_next, w_rx_word;
    logic                   w_abort, w_load, w_done, w_ovr_set, w_unr_set;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // A falling SS is only honoured once the synchronised SS has been seen
    // high after reset, so a reset in mid-frame cannot start a bogus frame.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_settle    <= '0;
            r_armed     <= 1'b0;
            r_sclk_q    <= 1'b0;
            r_ss_q      <= 1'b1;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            if (r_settle[SYNC_STAGES] && w_ss_s)
                r_armed <= 1'b1;
            r_sclk_q    <= w_sclk_s;
            r_ss_q      <= w_ss_s;
            r_rise      <= w_sclk_s & ~r_sclk_q;
            r_fall      <= ~w_sclk_s & r_sclk_q;
            r_ss_fall   <= r_armed & r_ss_q & ~w_ss_s;
            r_ss_rise   <= ~r_ss_q & w_ss_s;
            r_mosi      <= w_mosi_s;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DWIDTH; i++)
            w_mask[i] = (c_LW'(i) <= r_len);
    end

    assign w_rx_next = {r_rx_sh, r_mosi};
    assign w_rx_word = w_rx_next & w_mask;

    assign w_abort   = r_ss_rise;
    assign w_load    = !w_abort && (((r_state == ST_IDLE) && r_ss_fall) ||
                                    ((r_state == ST_RELOAD) && r_fall));
    assign w_done    = !w_abort && (r_state == ST_SHIFT) && r_rise && (r_bitcnt == r_len);
    assign w_ovr_set = w_done && r_rvalid && !RENA;
    assign w_unr_set = w_load && !r_tx_full;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_bitcnt   <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_tx_buf   <= '0;
            r_tx_full  <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_int      <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            r_busy     <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            r_int      <= w_done;
            r_overrun  <= w_ovr_set | (r_overrun & ~ERR_CLR);
            r_underrun <= w_unr_set | (r_underrun & ~ERR_CLR);
            // The shifter reads the old buffer word, so a coincident WENA
            // stays pending for the next frame.
            r_tx_full  <= WENA | (r_tx_full & ~w_load);
            if (WENA)
                r_tx_buf <= WDATA;

            if (w_done)
                r_rvalid <= 1'b1;
            else if (RENA)
                r_rvalid <= 1'b0;
            if (w_done && !w_ovr_set)
                r_rdata <= w_rx_word;

            if (w_load) begin
                r_len    <= LENGTH;
                r_tx_sh  <= r_tx_full ? r_tx_buf : '0;
                r_bitcnt <= '0;
                r_state  <= ST_SHIFT;
                r_busy   <= 1'b1;
                r_oe     <= 1'b1;
            end else if (w_abort) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_oe     <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                if (r_rise) begin
                    r_rx_sh  <= w_rx_next[DWIDTH-2:0];
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == r_len)
                        r_state <= ST_RELOAD;
                end else if (r_fall) begin
                    r_tx_sh <= r_tx_sh << 1;
                end
            end
        end
    end

    assign SPI_MISO    = r_oe & r_tx_sh[r_len];
    assign SPI_MISO_OE = r_oe;
    assign RDATA       = r_rdata;
    assign RVALID      = r_rvalid;
    assign TX_FULL     = r_tx_full;
    assign BUSY        = r_busy;
    assign OVERRUN     = r_overrun;
    assign UNDERRUN    = r_underrun;
    assign INT         = r_int;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Scoreboard bench for spi_slave driven by a mode-0 SPI master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int H = 4;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        SPI_CLK = 1'b0;
    logic        SPI_SS = 1'b1;
    logic        SPI_MOSI = 1'b0;
    logic        SPI_MISO, SPI_MISO_OE;
    logic [31:0] WDATA = '0;
    logic        WENA = 1'b0;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RENA = 1'b0;
    logic [4:0]  LENGTH = 5'd7;
    logic        TX_FULL, BUSY, OVERRUN, UNDERRUN;
    logic        ERR_CLR = 1'b0;
    logic        INT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        prev_int = 1'b0;

    spi_slave #(.DWIDTH(32), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .SPI_CLK(SPI_CLK), .SPI_SS(SPI_SS), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
        .WDATA(WDATA), .WENA(WENA), .RDATA(RDATA), .RVALID(RVALID), .RENA(RENA),
        .LENGTH(LENGTH), .TX_FULL(TX_FULL), .BUSY(BUSY), .OVERRUN(OVERRUN),
        .UNDERRUN(UNDERRUN), .ERR_CLR(ERR_CLR), .INT(INT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: every INT pops one expected RDATA word; INT must last one cycle.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (prev_int) begin
            checks++;
            if (INT !== 1'b0) begin
                errors++;
                $display("FAIL int_width INT=%b still high, required 0", INT);
            end
        end
        if (INT === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_int RDATA=%h, no frame expected", RDATA);
            end else begin
                e = exp_q.pop_front();
                if (RDATA !== e || RVALID !== 1'b1) begin
                    errors++;
                    $display("FAIL rdata got=%h rvalid=%b required=%h rvalid=1", RDATA, RVALID, e);
                end
            end
        end
        prev_int = INT;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] d);
        WDATA = d; WENA = 1'b1;
        wait_clk(1);
        WENA = 1'b0;
    endtask

    task automatic rd();
        RENA = 1'b1;
        wait_clk(1);
        RENA = 1'b0;
    endtask

    task automatic err_clr();
        ERR_CLR = 1'b1;
        wait_clk(1);
        ERR_CLR = 1'b0;
    endtask

    task automatic ss_low();
        SPI_SS = 1'b0;
        wait_clk(8);
    endtask

    task automatic ss_high();
        wait_clk(H);
        SPI_SS = 1'b1;
        wait_clk(8);
    endtask

    // Mode 0 master: data set while SCLK low, MISO sampled just before the rise.
    task automatic shift_bits(input logic [31:0] tx, input int nb, input int from,
                              input int to, output logic [31:0] rx);
        logic [31:0] acc = '0;
        for (int i = from; i < to; i++) begin
            SPI_MOSI = tx[nb-1-i];
            wait_clk(H);
            acc = {acc[30:0], SPI_MISO};
            SPI_CLK = 1'b1;
            wait_clk(H);
            SPI_CLK = 1'b0;
        end
        rx = acc;
    endtask

    initial begin
        logic [31:0] m1, m2;

        // Reset state
        wait_clk(5);
        chk("reset_outs", {31'd0, SPI_MISO, SPI_MISO_OE, RVALID, TX_FULL, BUSY, OVERRUN, UNDERRUN, INT}, 32'd0);
        chk("reset_rdata", RDATA, 32'd0);
        RESETn = 1'b1;
        wait_clk(8);

        // 8-bit frame, TX 0xA5, RX 0x3C
        LENGTH = 5'd7;
        wr(32'hA5);
        chk("tx_full_set", {31'd0, TX_FULL}, 32'd1);
        exp_q.push_back(32'h3C);
        ss_low();
        chk("busy_oe", {30'd0, BUSY, SPI_MISO_OE}, 32'd3);
        shift_bits(32'h3C, 8, 0, 8, m1);
        ss_high();
        chk("miso_a5", m1, 32'hA5);
        chk("rvalid_1", {31'd0, RVALID}, 32'd1);
        chk("tx_full_clr", {31'd0, TX_FULL}, 32'd0);
        chk("idle_busy_oe", {30'd0, BUSY, SPI_MISO_OE}, 32'd0);
        rd();
        chk("rena_clr", {31'd0, RVALID}, 32'd0);

        // 32-bit frame
        LENGTH = 5'd31;
        wr(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        ss_low();
        shift_bits(32'h12345678, 32, 0, 32, m1);
        ss_high();
        chk("miso_32", m1, 32'hDEADBEEF);
        rd();

        // Back-to-back frames, second overruns
        err_clr();
        LENGTH = 5'd7;
        wr(32'h11);
        exp_q.push_back(32'h81);
        exp_q.push_back(32'h81);
        ss_low();
        fork
            shift_bits(32'h81, 8, 0, 8, m1);
            begin wait_clk(20); wr(32'h22); end
        join
        shift_bits(32'h42, 8, 0, 8, m2);
        ss_high();
        chk("b2b_miso1", m1, 32'h11);
        chk("b2b_miso2", m2, 32'h22);
        chk("overrun_set", {31'd0, OVERRUN}, 32'd1);
        chk("overrun_rdata", RDATA, 32'h81);
        err_clr();
        chk("overrun_clr", {31'd0, OVERRUN}, 32'd0);
        rd();

        // Underrun: no WENA
        err_clr();
        chk("underrun_pre", {31'd0, UNDERRUN}, 32'd0);
        exp_q.push_back(32'h5A);
        ss_low();
        chk("underrun_set", {31'd0, UNDERRUN}, 32'd1);
        shift_bits(32'h5A, 8, 0, 8, m1);
        ss_high();
        chk("underrun_miso", m1, 32'h0);
        err_clr();
        chk("underrun_clr", {31'd0, UNDERRUN}, 32'd0);
        rd();

        // Abort after 5 bits, then a full frame
        wr(32'h77);
        ss_low();
        shift_bits(32'hB6, 8, 0, 5, m1);
        ss_high();
        chk("abort_state", {30'd0, RVALID, BUSY}, 32'd0);
        wr(32'h3E);
        exp_q.push_back(32'hC3);
        ss_low();
        shift_bits(32'hC3, 8, 0, 8, m1);
        ss_high();
        chk("after_abort_miso", m1, 32'h3E);
        rd();

        // Reset in mid-frame
        wr(32'h99);
        ss_low();
        shift_bits(32'hF0, 8, 0, 3, m1);
        RESETn = 1'b0;
        #1;
        chk("midrst_outs", {31'd0, SPI_MISO, SPI_MISO_OE, RVALID, TX_FULL, BUSY, OVERRUN, UNDERRUN, INT}, 32'd0);
        chk("midrst_rdata", RDATA, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        shift_bits(32'hF0, 8, 3, 8, m1);
        chk("midrst_ignored", {30'd0, RVALID, BUSY}, 32'd0);
        ss_high();
        wr(32'h5C);
        exp_q.push_back(32'hE7);
        ss_low();
        shift_bits(32'hE7, 8, 0, 8, m1);
        ss_high();
        chk("post_rst_miso", m1, 32'h5C);
        rd();

        wait_clk(20);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
